// File: rtl/axil_uart_rx.sv
// AXI4-Lite UART receiver: 8N1 deserialiser, RX FIFO, sticky status and level IRQ.
// Define AXIL_UART_RX_PARITY_EN for 8E1 framing with a parity-error flag in STATUS[3].
module axil_uart_rx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset_reset,
    input  logic        rx_serial,
    output logic        rx_irq,
    input  logic [31:0] csr_agent_awaddr,
    input  logic [2:0]  csr_agent_awsize,
    input  logic [2:0]  csr_agent_awprot,
    input  logic        csr_agent_awvalid,
    output logic        csr_agent_awready,
    input  logic [31:0] csr_agent_wdata,
    input  logic [3:0]  csr_agent_wstrb,
    input  logic        csr_agent_wlast,
    input  logic        csr_agent_wvalid,
    output logic        csr_agent_wready,
    output logic [1:0]  csr_agent_bresp,
    output logic        csr_agent_bvalid,
    input  logic        csr_agent_bready,
    input  logic [31:0] csr_agent_araddr,
    input  logic [2:0]  csr_agent_arsize,
    input  logic [2:0]  csr_agent_arprot,
    input  logic        csr_agent_arvalid,
    output logic        csr_agent_arready,
    output logic [31:0] csr_agent_rdata,
    output logic [1:0]  csr_agent_rresp,
    output logic        csr_agent_rvalid,
    input  logic        csr_agent_rready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef AXIL_UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [1:0]  r_ctrl;
    logic [15:0] r_div;
    logic        r_ovr, r_fe, r_pe;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic        r_wr_rdy, r_bvalid, r_arready, r_rvalid, r_irq;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic        w_rx, w_fall, w_tick, w_push, w_fe_set, w_pe_set;
    logic [15:0] w_tgt, w_div_mrg, w_div_new;
    logic        w_empty, w_full, w_wr, w_rd, w_aw_bad, w_ar_bad, w_pop, w_wen, w_ovr_set;
    logic [3:0]  w_w1c;
    logic [8:0]  w_cnt9;
    logic [7:0]  w_cnt8;
    logic [31:0] w_status, w_rmux;
    logic        w_unused;

    assign w_rx   = r_rx_s2;
    assign w_fall = r_rx_prev & ~r_rx_s2;
    // START waits half a bit so every later sample lands mid-bit.
    assign w_tgt  = (r_state == S_START) ? {1'b0, r_div[15:1]} : r_div;
    assign w_tick = (r_cnt >= w_tgt - 16'd1);

    assign w_push   = r_ctrl[1] && (r_state == S_STOP) && w_tick && w_rx;
    assign w_fe_set = r_ctrl[1] && (r_state == S_STOP) && w_tick && !w_rx;
`ifdef AXIL_UART_RX_PARITY_EN
    assign w_pe_set = r_ctrl[1] && (r_state == S_PARITY) && w_tick && (w_rx != ^r_shift);
`else
    assign w_pe_set = 1'b0;
`endif

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr      = r_wr_rdy & csr_agent_awvalid & csr_agent_wvalid;
    assign w_rd      = r_arready & csr_agent_arvalid;
    assign w_aw_bad  = |csr_agent_awaddr[31:4];
    assign w_ar_bad  = |csr_agent_araddr[31:4];
    assign w_pop     = w_rd && !w_ar_bad && (csr_agent_araddr[3:2] == 2'd0) && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wen     = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;
    assign w_w1c     = (w_wr && !w_aw_bad && (csr_agent_awaddr[3:2] == 2'd1) && csr_agent_wstrb[0])
                       ? csr_agent_wdata[3:0] : 4'h0;

    assign w_div_mrg = {csr_agent_wstrb[1] ? csr_agent_wdata[15:8] : r_div[15:8],
                        csr_agent_wstrb[0] ? csr_agent_wdata[7:0]  : r_div[7:0]};
    assign w_div_new = (w_div_mrg < 16'd4) ? 16'd4 : w_div_mrg;

    assign w_cnt9   = 9'(r_count);
    assign w_cnt8   = w_cnt9[8] ? 8'hFF : w_cnt9[7:0];
    assign w_status = {16'h0, w_cnt8, 4'h0, r_pe, r_fe, r_ovr, !w_empty};

    always_comb begin
        w_rmux = 32'h0;
        case (csr_agent_araddr[3:2])
            2'd0: w_rmux = w_empty ? 32'h0 : {24'h0, r_mem[r_rp]};
            2'd1: w_rmux = w_status;
            2'd2: w_rmux = {30'h0, r_ctrl};
            2'd3: w_rmux = {16'h0, r_div};
        endcase
    end

    assign w_unused = ^{csr_agent_awsize, csr_agent_awprot, csr_agent_wlast, csr_agent_arsize,
                        csr_agent_arprot, csr_agent_awaddr[1:0], csr_agent_araddr[1:0],
                        csr_agent_wdata[31:16], csr_agent_wstrb[3:2], w_w1c};

    always_ff @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_serial;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (!r_ctrl[1]) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                        r_bit   <= '0;
                    end
                end
                S_START: if (w_tick) r_state <= w_rx ? S_IDLE : S_DATA;
                S_DATA: if (w_tick) begin
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
`ifdef AXIL_UART_RX_PARITY_EN
                    if (r_bit == 3'd7) r_state <= S_PARITY;
`else
                    if (r_bit == 3'd7) r_state <= S_STOP;
`endif
                end
`ifdef AXIL_UART_RX_PARITY_EN
                S_PARITY: if (w_tick) r_state <= S_STOP;
`endif
                S_STOP: if (w_tick) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen) r_mem[r_wp] <= r_shift;
    end

    always_ff @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wen) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_wen && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wen && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_ctrl <= '0;
            r_div  <= DIV_RESET;
            r_ovr  <= 1'b0;
            r_fe   <= 1'b0;
            r_pe   <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && !w_aw_bad && (csr_agent_awaddr[3:2] == 2'd2) && csr_agent_wstrb[0])
                r_ctrl <= csr_agent_wdata[1:0];
            if (w_wr && !w_aw_bad && (csr_agent_awaddr[3:2] == 2'd3))
                r_div <= w_div_new;
            // Hardware set beats a same-cycle W1C.
            r_ovr <= w_ovr_set | (r_ovr & ~w_w1c[1]);
            r_fe  <= w_fe_set  | (r_fe  & ~w_w1c[2]);
`ifdef AXIL_UART_RX_PARITY_EN
            r_pe  <= w_pe_set  | (r_pe  & ~w_w1c[3]);
`else
            r_pe  <= w_pe_set;
`endif
            r_irq <= r_ctrl[0] & (!w_empty | r_ovr);
        end
    end

    always_ff @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wr_rdy  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_wr_rdy <= csr_agent_awvalid & csr_agent_wvalid & !r_bvalid & !r_wr_rdy;
            if (w_wr) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_bad ? 2'b10 : 2'b00;
            end else if (r_bvalid && csr_agent_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_ar_bad ? 32'h0 : w_rmux;
                r_rresp   <= w_ar_bad ? 2'b10 : 2'b00;
            end else if (r_rvalid && csr_agent_rready) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end else if (!r_rvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    assign rx_irq            = r_irq;
    assign csr_agent_awready = r_wr_rdy;
    assign csr_agent_wready  = r_wr_rdy;
    assign csr_agent_bvalid  = r_bvalid;
    assign csr_agent_bresp   = r_bresp;
    assign csr_agent_arready = r_arready;
    assign csr_agent_rvalid  = r_rvalid;
    assign csr_agent_rdata   = r_rdata;
    assign csr_agent_rresp   = r_rresp;
endmodule

// File: tb/tb_axil_uart_rx.sv
// Directed bench for axil_uart_rx: register access, 8N1/8E1 reception, FIFO overrun, errors.
module tb_axil_uart_rx;
    localparam int BIT = 8;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        rx_serial;
    logic        rx_irq;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int errors = 0;
    int checks = 0;
    logic [31:0] d;
    logic [1:0]  resp;

    always #5 clk = ~clk;

    axil_uart_rx #(.FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
        .clk(clk), .reset_reset(reset_reset), .rx_serial(rx_serial), .rx_irq(rx_irq),
        .csr_agent_awaddr(awaddr), .csr_agent_awsize(awsize), .csr_agent_awprot(awprot),
        .csr_agent_awvalid(awvalid), .csr_agent_awready(awready),
        .csr_agent_wdata(wdata), .csr_agent_wstrb(wstrb), .csr_agent_wlast(wlast),
        .csr_agent_wvalid(wvalid), .csr_agent_wready(wready),
        .csr_agent_bresp(bresp), .csr_agent_bvalid(bvalid), .csr_agent_bready(bready),
        .csr_agent_araddr(araddr), .csr_agent_arsize(arsize), .csr_agent_arprot(arprot),
        .csr_agent_arvalid(arvalid), .csr_agent_arready(arready),
        .csr_agent_rdata(rdata), .csr_agent_rresp(rresp), .csr_agent_rvalid(rvalid),
        .csr_agent_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        errors++;
        $error("FAIL %s: timed out waiting for handshake", tag);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s,
                             output logic [1:0] r);
        int n = 0;
        awaddr = a; wdata = v; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        r = 2'b11;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bvalid) timeout("b_response");
        r = bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] v, output logic [1:0] r);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        v = 32'hDEAD_BEEF; r = 2'b11;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) timeout("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rvalid) timeout("r_response");
        v = rdata; r = rresp;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        logic [1:0] r;
        axi_write(a, v, 4'hF, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        logic [1:0] r;
        axi_read(a, v, r);
    endtask

    // 8N1 frame (8E1 under the parity macro, with an explicit parity bit).
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par);
        rx_serial = 1'b0;
        repeat (BIT) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (BIT) @(posedge clk); #1;
        end
`ifdef AXIL_UART_RX_PARITY_EN
        rx_serial = par;
        repeat (BIT) @(posedge clk); #1;
`else
        if (par === 1'bz) rx_serial = 1'b1;
`endif
        rx_serial = stop;
        repeat (BIT) @(posedge clk); #1;
        rx_serial = 1'b1;
        repeat (4) @(posedge clk); #1;
    endtask

    initial begin
        reset_reset = 1'b1; rx_serial = 1'b1;
        awaddr = '0; wdata = '0; araddr = '0; awsize = 3'd2; awprot = '0; arsize = 3'd2;
        arprot = '0; awvalid = 0; wvalid = 0; wstrb = '0; wlast = 1'b1; bready = 1'b1;
        arvalid = 0; rready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("reset_ctrl_outs", {29'h0, awready, wready, arready}, 32'h0);
        chk("reset_valids_irq", {26'h0, bvalid, rvalid, rx_irq, 1'b0, bresp}, 32'h0);
        chk("reset_rdata_rresp", {rdata[29:0], rresp}, 32'h0);
        reset_reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        axi_read(32'h4, d, resp);
        chk("status_reset", d, 32'h0);
        chk("status_reset_rresp", {30'h0, resp}, 32'h0);
        rd(32'hC, d);
        chk("div_reset", d, 32'd434);

        axi_write(32'hC, 32'h1, 4'hF, resp);
        chk("div_write_bresp", {30'h0, resp}, 32'h0);
        rd(32'hC, d);
        chk("div_clamp", d, 32'd4);
        axi_write(32'hC, 32'h1234, 4'b0001, resp);
        rd(32'hC, d);
        chk("div_wstrb_lane0", d, 32'h0034);
        wr(32'hC, 32'd8);
        wr(32'h8, 32'h3);
        rd(32'h8, d);
        chk("ctrl_rw", d, 32'h3);

        send_byte(8'hA5, 1'b1, ^8'hA5);
        chk("irq_on_data", {31'h0, rx_irq}, 32'h1);
        rd(32'h4, d);
        chk("status_one_byte", d, 32'h0101);
        rd(32'h0, d);
        chk("rxdata_a5", d, 32'hA5);
        rd(32'h4, d);
        chk("status_after_pop", d, 32'h0);
        chk("irq_after_pop", {31'h0, rx_irq}, 32'h0);
        rd(32'h0, d);
        chk("rxdata_empty", d, 32'h0);

        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, ^(8'(i)));
        rd(32'h4, d);
        chk("status_full_overrun", d, 32'h1003);
        for (int i = 0; i < 16; i++) begin
            rd(32'h0, d);
            chk($sformatf("fifo_pop_%0d", i), d, 32'(i));
        end
        rd(32'h4, d);
        chk("status_overrun_only", d, 32'h0002);
        chk("irq_on_overrun", {31'h0, rx_irq}, 32'h1);
        wr(32'h4, 32'h2);
        rd(32'h4, d);
        chk("overrun_w1c", d, 32'h0);
        chk("irq_after_w1c", {31'h0, rx_irq}, 32'h0);

        send_byte(8'h55, 1'b0, ^8'h55);
        rd(32'h4, d);
        chk("frame_error", d, 32'h0004);
        axi_write(32'h4, 32'h4, 4'b0010, resp);
        rd(32'h4, d);
        chk("w1c_needs_lane0", d, 32'h0004);
        axi_write(32'h4, 32'h4, 4'b0001, resp);
        rd(32'h4, d);
        chk("frame_error_w1c", d, 32'h0);

        rx_serial = 1'b0;
        repeat (2) @(posedge clk); #1;
        rx_serial = 1'b1;
        repeat (30) @(posedge clk); #1;
        rd(32'h4, d);
        chk("glitch_ignored", d, 32'h0);
        send_byte(8'h3C, 1'b1, ^8'h3C);
        rd(32'h0, d);
        chk("rx_after_glitch", d, 32'h3C);

        wr(32'h8, 32'h1);
        send_byte(8'h77, 1'b1, ^8'h77);
        rd(32'h4, d);
        chk("rx_disabled", d, 32'h0);
        wr(32'h8, 32'h3);

        axi_read(32'h10, d, resp);
        chk("slverr_rdata", d, 32'h0);
        chk("slverr_rresp", {30'h0, resp}, 32'h2);
        axi_write(32'h18, 32'h0, 4'hF, resp);
        chk("slverr_bresp", {30'h0, resp}, 32'h2);
        rd(32'h8, d);
        chk("slverr_no_write", d, 32'h3);

        awaddr = 32'h8; wdata = 32'h3; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!awready && n < 50) begin @(negedge clk); n++; end
            if (!awready) timeout("bhold_aw");
        end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bhold_%0d", k), {30'h0, bvalid, awready}, 32'h2);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        chk("bhold_release", {31'h0, bvalid}, 32'h0);

`ifdef AXIL_UART_RX_PARITY_EN
        send_byte(8'h03, 1'b1, 1'b1);
        rd(32'h4, d);
        chk("parity_error", d, 32'h0109);
        rd(32'h0, d);
        chk("parity_byte_kept", d, 32'h03);
        wr(32'h4, 32'h8);
        rd(32'h4, d);
        chk("parity_w1c", d, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axil_uart_rx.md
# axil_uart_rx

AXI4-Lite subordinate UART receiver that hangs off the processor's `data_manager` port and drives one bit of `platform_irq_rx_irq`. It deserialises an 8N1 serial line, buffers received bytes in a FIFO, exposes data, status and control registers, and raises a level interrupt when data is waiting or an overrun has occurred.

## Interface

**Parameters**

- `FIFO_DEPTH`, default 16: receive FIFO entries; power of two, 2–256.
- `DIV_RESET`, default 16'd434: reset value of the baud divisor (115200 baud at 50 MHz).

**Ports**

- `clk` in 1: single clock for all logic.
- `reset_reset` in 1: asynchronous, active-high reset.
- `rx_serial` in 1: UART line, idle high, asynchronous to `clk`.
- `rx_irq` out 1: level interrupt, wired to one bit of `platform_irq_rx_irq`.
- `csr_agent_awaddr` in 32: write address; only bits [3:2] are decoded, bits [31:4] must be zero.
- `csr_agent_awsize`, `csr_agent_awprot` in 3 each: accepted and ignored.
- `csr_agent_awvalid` in 1, `csr_agent_awready` out 1: write-address handshake.
- `csr_agent_wdata` in 32, `csr_agent_wstrb` in 4, `csr_agent_wlast` in 1: write data; `wlast` is ignored.
- `csr_agent_wvalid` in 1, `csr_agent_wready` out 1: write-data handshake.
- `csr_agent_bresp` out 2, `csr_agent_bvalid` out 1, `csr_agent_bready` in 1: write response.
- `csr_agent_araddr` in 32, `csr_agent_arsize` in 3, `csr_agent_arprot` in 3: read address; `arsize` and `arprot` are ignored.
- `csr_agent_arvalid` in 1, `csr_agent_arready` out 1: read-address handshake.
- `csr_agent_rdata` out 32, `csr_agent_rresp` out 2, `csr_agent_rvalid` out 1, `csr_agent_rready` in 1: read data.

## Operation

**Register map** (undriven read bits return 0)

- 0x0 `RXDATA` (RO)
  - [7:0] is the FIFO head.
  - A read pops the FIFO. Reading while the FIFO is empty returns 0 and does not pop.
- 0x4 `STATUS`
  - [0] not-empty.
  - [1] overrun, sticky, write 1 to clear (W1C).
  - [2] frame error, sticky, W1C.
  - [3] parity error, sticky, W1C (this bit exists only under the macro; see Configuration).
  - [15:8] FIFO count.
- 0x8 `CTRL` (RW, reset 0): [0] irq enable, [1] receiver enable.
- 0xC `DIV` (RW, reset `DIV_RESET`): [15:0] clock cycles per bit. Written values below 4 are clamped to 4.
- Any address with bits [31:4] non-zero: response SLVERR (2'b10), read data 0, write has no effect.
- `wstrb` applies per byte on `CTRL` and `DIV`. For `STATUS` W1C, byte lane 0 must be enabled.

**Receiver**

- `rx_serial` passes through a 2-flop synchroniser. All decisions use the synchronised value.
- States:
  - IDLE: a high-to-low edge with receiver enable set → START, bit counter reset.
  - START: after DIV/2 cycles, sample the line. Low → DATA. High → IDLE (false start, nothing recorded).
  - DATA: sample every DIV cycles, 8 bits, LSB first → STOP (→ PARITY under the macro).
  - STOP: sample after DIV cycles.
    - High: push the byte.
    - Low: set frame error and discard the byte.
    - In both cases → IDLE.
- Clearing receiver enable forces the FSM to IDLE within one cycle; a partial byte is discarded.
- Push while the FIFO is full: the byte is dropped, overrun is set, FIFO contents are unchanged.
- `rx_irq` = irq enable & (not-empty | overrun), registered.

## Timing

**Reset values**

- All `*ready`, `bvalid`, `rvalid`, `rx_irq` = 0.
- `bresp`, `rresp`, `rdata` = 0.
- FIFO empty, sticky flags 0, FSM in IDLE.

**Write channel**

- `awready` and `wready` assert together for one cycle when `awvalid`, `wvalid` and no pending B response are all present. AW and W must both be valid; neither is accepted alone.
- The register update takes effect on the handshake edge.
- `bvalid` rises the next cycle and holds until `bready`.

**Read channel**

- `arready` = !`rvalid`.
- `rvalid` and `rdata` are registered one cycle after the AR handshake and hold until `rready`. Back-to-back throughput is one read per 2 cycles.
- The FIFO pops on the AR handshake, so `rdata` holds the pre-pop head.

**Simultaneous events**

- FIFO push and pop in the same cycle: count unchanged, both take effect.
- Hardware set and W1C of the same sticky flag in one cycle: the set wins.
- `rx_irq` follows its sources with 1 cycle of latency.

**Serial sampling**

- Line-to-sample latency is 2 cycles (synchroniser), on top of the bit timing.
- A byte is visible in `STATUS[0]` 1 cycle after the STOP sample.

## Configuration

- `AXIL_UART_RX_PARITY_EN` defined:
  - Frame is 8E1. The PARITY state samples the parity bit one DIV after the last data bit.
  - On mismatch, `STATUS[3]` is set and the byte is still pushed.
- Not defined:
  - Frame is 8N1. The PARITY state does not exist and `STATUS[3]` reads 0.

## Test plan

- Reset, then read 0x4 → `rdata`=0, `rresp`=0. Read 0xC → 434. `rx_irq`=0.
- Write `DIV`=8 and `CTRL`=3, send 0xA5 8N1 at 8 cycles/bit → `STATUS`=0x0101, `rx_irq`=1. Read 0x0 → 0xA5. Then `STATUS`=0, `rx_irq`=0.
- `DIV`=8, send 17 bytes 0x00..0x10 with `FIFO_DEPTH`=16 → count 16, overrun=1. Read 0x0 16 times → 0x00..0x0F. Write 0x4=0x2 → overrun clears.
- Send 0x55 with the stop bit held low → frame error=1, count 0. Drive a 2-cycle low glitch → no state change.
- Read to 0x10 → SLVERR with `rdata`=0. Hold `bready`=0 for 5 cycles after a write → `bvalid` stays 1, `awready` stays 0.
- With `AXIL_UART_RX_PARITY_EN`: send 0x03 with parity bit 1 → `STATUS[3]`=1, byte 0x03 is in the FIFO.
